// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, bubble encoding, reset vector
// and the fetch FSM state encoding.
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction that returns while decode is stalled.
module fetch_skid_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic            drain,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_pc4,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);

    // Clear wins over load: a redirect makes any returning instruction wrong-path.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
            pc4   <= load_pc4;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, one-outstanding imem requests, redirect/stall/flush
// handling and the IF/ID pipeline register.
module fetch_stage #(
    parameter int              XLEN      = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            br_selE,
    input  logic [XLEN-1:0] br_targetE,
    fetch_stage_if.master   imem,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pc4D,
    output logic            validD
);
    import core_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] tag_pc;
    logic [XLEN-1:0] tag_pc4;

    logic            accept;
    logic            issue;
    logic            hs;

    logic            skid_valid;
    logic            skid_load;
    logic            skid_drain;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_pc4;

    assign pc_plus4 = pc + XLEN'(4);
    assign accept   = (state == WAIT) && imem.imem_rvalid && !br_selE;

    // Never issue while a returning instruction would have nowhere to go.
    assign issue = ((state == REQ) || ((state == WAIT) && imem.imem_rvalid))
                   && !stallF && !br_selE && !skid_valid && !(accept && stallD);
    assign hs    = issue && imem.imem_gnt;

    assign imem.imem_req  = issue;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            tag_pc  <= '0;
            tag_pc4 <= '0;
        end else if (br_selE) begin
            pc <= br_targetE;
            // The in-flight response (if any) belongs to the wrong path.
            case (state)
                WAIT, DROP: state <= imem.imem_rvalid ? REQ : DROP;
                default:    state <= REQ;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ, WAIT: begin
                    if (hs) begin
                        pc      <= pc_plus4;
                        tag_pc  <= pc;
                        tag_pc4 <= pc_plus4;
                        state   <= WAIT;
                    end else if ((state == WAIT) && imem.imem_rvalid) begin
                        state <= REQ;
                    end
                end
                DROP: if (imem.imem_rvalid) state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end

    assign skid_load  = accept && stallD;
    assign skid_drain = skid_valid && !stallD && !flushD;

    fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .clear      (br_selE),
        .load       (skid_load),
        .drain      (skid_drain),
        .load_instr (imem.imem_rdata),
        .load_pc    (tag_pc),
        .load_pc4   (tag_pc4),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc),
        .pc4        (skid_pc4)
    );

    // IF/ID register; bubbles keep the last PC so debug traces stay readable.
    always_ff @(posedge clk) begin
        if (rst) begin
            instrD <= NOP_INSTR;
            pcD    <= '0;
            pc4D   <= '0;
            validD <= 1'b0;
        end else if (!stallD) begin
            if (flushD) begin
                instrD <= NOP_INSTR;
                validD <= 1'b0;
            end else if (skid_valid) begin
                instrD <= skid_instr;
                pcD    <= skid_pc;
                pc4D   <= skid_pc4;
                validD <= 1'b1;
            end else if (accept) begin
                instrD <= imem.imem_rdata;
                pcD    <= tag_pc;
                pc4D   <= tag_pc4;
                validD <= 1'b1;
            end else begin
                instrD <= NOP_INSTR;
                validD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small latency-configurable imem responder.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF, stallD, flushD, br_selE;
    logic [31:0] br_targetE;
    logic [31:0] instrD, pcD, pc4D;
    logic        validD;

    fetch_stage_if #(.XLEN(32)) imem_bus ();

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .br_selE    (br_selE),
        .br_targetE (br_targetE),
        .imem       (imem_bus),
        .instrD     (instrD),
        .pcD        (pcD),
        .pc4D       (pc4D),
        .validD     (validD)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int          mem_lat = 1;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    logic [96:0] got, exp;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {8'hC3, a[23:0]};
    endfunction

    // Memory: responds mem_lat cycles after the grant, sampled just before the edge.
    initial begin
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = '0;
        pend = 1'b0; pend_cnt = 0; pend_addr = '0;
        forever begin
            @(negedge clk);
            imem_bus.imem_rvalid = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt <= 0) begin
                    imem_bus.imem_rvalid = 1'b1;
                    imem_bus.imem_rdata  = memw(pend_addr);
                    pend = 1'b0;
                end
            end
            #4;
            if (imem_bus.imem_req === 1'b1 && imem_bus.imem_gnt === 1'b1) begin
                pend      = 1'b1;
                pend_cnt  = mem_lat;
                pend_addr = imem_bus.imem_addr;
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 after release: FSM in REQ, nothing fetched yet.
    task automatic rel_reset();
        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        br_selE = 1'b0; br_targetE = '0; imem_bus.imem_gnt = 1'b1; mem_lat = 1;
        repeat (4) nxt();
        rst = 1'b0;
        nxt();
    endtask

    task automatic test_reset();
        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        br_selE = 1'b0; br_targetE = '0; imem_bus.imem_gnt = 1'b1;
        repeat (3) nxt();
        #1;
        got = {instrD, pcD, pc4D, validD}; exp = {32'h0000_0013, 32'h0, 32'h0, 1'b0};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL reset_ifid got=%h exp=%h", got, exp); end
        n_vec++;
        if (imem_bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", imem_bus.imem_req); end
    endtask

    task automatic test_stream();
        rel_reset();
        for (int j = 1; j <= 8; j++) begin
            #1;
            n_vec++;
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'(4*(j-1))) begin
                n_bad++;
                $display("FAIL stream_req j=%0d got req=%b addr=%h exp req=1 addr=%h", j, imem_bus.imem_req, imem_bus.imem_addr, 32'(4*(j-1)));
            end
            n_vec++;
            if (j >= 3) begin
                got = {instrD, pcD, pc4D, validD};
                exp = {memw(32'(4*(j-3))), 32'(4*(j-3)), 32'(4*(j-2)), 1'b1};
                if (got !== exp) begin n_bad++; $display("FAIL stream_ifid j=%0d got=%h exp=%h", j, got, exp); end
            end else if (validD !== 1'b0) begin
                n_bad++; $display("FAIL stream_valid j=%0d got=%b exp=0", j, validD);
            end
            nxt();
        end
    endtask

    task automatic test_stall_d();
        rel_reset();
        repeat (3) nxt();
        for (int c = 4; c <= 6; c++) begin
            stallD = 1'b1;
            #1;
            got = {instrD, pcD, pc4D, validD}; exp = {memw(32'h4), 32'h4, 32'h8, 1'b1};
            n_vec++;
            if (got !== exp || imem_bus.imem_req !== 1'b0) begin
                n_bad++; $display("FAIL stallD_hold c=%0d got=%h req=%b exp=%h req=0", c, got, imem_bus.imem_req, exp);
            end
            nxt();
        end
        stallD = 1'b0;
        #1;
        n_vec++;
        if (imem_bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL stallD_skid_full_req got=%b exp=0", imem_bus.imem_req); end
        nxt(); #1;
        got = {instrD, pcD, pc4D, validD}; exp = {memw(32'h8), 32'h8, 32'hC, 1'b1};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL stallD_drain got=%h exp=%h", got, exp); end
        n_vec++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'hC) begin
            n_bad++; $display("FAIL stallD_resume got req=%b addr=%h exp req=1 addr=0000000c", imem_bus.imem_req, imem_bus.imem_addr);
        end
        nxt(); #1;
        n_vec++;
        if (validD !== 1'b0) begin n_bad++; $display("FAIL stallD_gap got=%b exp=0", validD); end
        nxt(); #1;
        got = {instrD, pcD, pc4D, validD}; exp = {memw(32'hC), 32'hC, 32'h10, 1'b1};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL stallD_next got=%h exp=%h", got, exp); end
    endtask

    task automatic test_redirect();
        rel_reset();
        mem_lat = 3;
        nxt();
        br_selE = 1'b1; br_targetE = 32'h100;
        #1;
        n_vec++;
        if (imem_bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_wait_req got=%b exp=0", imem_bus.imem_req); end
        nxt();
        br_selE = 1'b0;
        #1;
        n_vec++;
        if (imem_bus.imem_addr !== 32'h100 || imem_bus.imem_req !== 1'b0 || validD !== 1'b0) begin
            n_bad++; $display("FAIL redir_drop got addr=%h req=%b v=%b exp addr=00000100 req=0 v=0", imem_bus.imem_addr, imem_bus.imem_req, validD);
        end
        nxt(); #1;
        n_vec++;
        if (imem_bus.imem_req !== 1'b0 || validD !== 1'b0) begin
            n_bad++; $display("FAIL redir_stale got req=%b v=%b exp req=0 v=0", imem_bus.imem_req, validD);
        end
        nxt();
        mem_lat = 1;
        #1;
        n_vec++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100 || validD !== 1'b0) begin
            n_bad++; $display("FAIL redir_target_req got req=%b addr=%h v=%b exp req=1 addr=00000100 v=0", imem_bus.imem_req, imem_bus.imem_addr, validD);
        end
        nxt(); #1;
        n_vec++;
        if (validD !== 1'b0 || imem_bus.imem_addr !== 32'h104) begin
            n_bad++; $display("FAIL redir_wait_tgt got v=%b addr=%h exp v=0 addr=00000104", validD, imem_bus.imem_addr);
        end
        nxt(); #1;
        got = {instrD, pcD, pc4D, validD}; exp = {memw(32'h100), 32'h100, 32'h104, 1'b1};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL redir_target_instr got=%h exp=%h", got, exp); end
    endtask

    task automatic test_flush();
        rel_reset();
        repeat (4) nxt();
        flushD = 1'b1;
        nxt();
        flushD = 1'b0;
        #1;
        got = {instrD, pcD, pc4D, validD}; exp = {32'h0000_0013, 32'h8, 32'hC, 1'b0};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL flush_bubble got=%h exp=%h", got, exp); end
        n_vec++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h14) begin
            n_bad++; $display("FAIL flush_continue got req=%b addr=%h exp req=1 addr=00000014", imem_bus.imem_req, imem_bus.imem_addr);
        end
        nxt(); #1;
        got = {instrD, pcD, pc4D, validD}; exp = {memw(32'h10), 32'h10, 32'h14, 1'b1};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL flush_next got=%h exp=%h", got, exp); end
    endtask

    task automatic test_gnt_low();
        rel_reset();
        for (int c = 1; c <= 4; c++) begin
            imem_bus.imem_gnt = 1'b0;
            #1;
            n_vec++;
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
                n_bad++; $display("FAIL gnt_low_hold c=%0d got req=%b addr=%h exp req=1 addr=00000000", c, imem_bus.imem_req, imem_bus.imem_addr);
            end
            nxt();
        end
        imem_bus.imem_gnt = 1'b1;
        nxt(); #1;
        n_vec++;
        if (imem_bus.imem_addr !== 32'h4 || validD !== 1'b0) begin
            n_bad++; $display("FAIL gnt_low_adv got addr=%h v=%b exp addr=00000004 v=0", imem_bus.imem_addr, validD);
        end
        nxt(); #1;
        got = {instrD, pcD, pc4D, validD}; exp = {memw(32'h0), 32'h0, 32'h4, 1'b1};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL gnt_low_instr got=%h exp=%h", got, exp); end
    endtask

    task automatic test_wrap();
        rel_reset();
        br_selE = 1'b1; br_targetE = 32'hFFFF_FFFC;
        #1;
        n_vec++;
        if (imem_bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL wrap_redir_req got=%b exp=0", imem_bus.imem_req); end
        nxt();
        br_selE = 1'b0;
        #1;
        n_vec++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'hFFFF_FFFC) begin
            n_bad++; $display("FAIL wrap_top got req=%b addr=%h exp req=1 addr=fffffffc", imem_bus.imem_req, imem_bus.imem_addr);
        end
        nxt(); #1;
        n_vec++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL wrap_zero got req=%b addr=%h exp req=1 addr=00000000", imem_bus.imem_req, imem_bus.imem_addr);
        end
        nxt(); #1;
        got = {instrD, pcD, pc4D, validD}; exp = {32'hC3FF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL wrap_instr got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_mid_wait();
        rel_reset();
        repeat (4) nxt();
        mem_lat = 3;
        nxt();
        rst = 1'b1;
        #1;
        got = {instrD, pcD, pc4D, validD}; exp = {memw(32'hC), 32'hC, 32'h10, 1'b1};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL rstmid_pre got=%h exp=%h", got, exp); end
        nxt();
        rst = 1'b0;
        #1;
        got = {instrD, pcD, pc4D, validD}; exp = {32'h0000_0013, 32'h0, 32'h0, 1'b0};
        n_vec++;
        if (got !== exp || imem_bus.imem_req !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_reset got=%h req=%b exp=%h req=0", got, imem_bus.imem_req, exp);
        end
        nxt();
        mem_lat = 1;
        #1;
        n_vec++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_req got req=%b addr=%h exp req=1 addr=00000000", imem_bus.imem_req, imem_bus.imem_addr);
        end
        nxt(); #1;
        n_vec++;
        if (validD !== 1'b0 || instrD !== 32'h0000_0013) begin
            n_bad++; $display("FAIL rstmid_stale got v=%b instr=%h exp v=0 instr=00000013", validD, instrD);
        end
        nxt(); #1;
        got = {instrD, pcD, pc4D, validD}; exp = {memw(32'h0), 32'h0, 32'h4, 1'b1};
        n_vec++;
        if (got !== exp) begin n_bad++; $display("FAIL rstmid_first got=%h exp=%h", got, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall_d();
        test_redirect();
        test_flush();
        test_gnt_low();
        test_wrap();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
